// File: rtl/disp_scan_ctrl.sv
// Display slot scanner: walks slots 0..4 with a programmable dwell per slot.
// Optional inter-slot blanking gap enabled by defining SCAN_BLANK_EN.
module disp_scan_ctrl #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 16,
    parameter int unsigned CW    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       hold,
    output logic [3:0] adress,
    output logic [4:0] digit_en,
    output logic [2:0] slot,
    output logic       frame_start
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } state_t;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
`endif

    if (DWELL < 1 || BLANK < 1 ||
        ((DWELL - 1) >> CW) != 0 ||
        ((BLANK - 1) >> CW) != 0) begin : g_bad_cfg
        $error("disp_scan_ctrl: DWELL/BLANK out of range");
    end

    state_t        state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    adress_q, adress_d;
    logic [4:0]    digit_en_q, digit_en_d;
    logic          frame_start_q, frame_start_d;

    function automatic logic [2:0] next_slot(input logic [2:0] s);
        return (s >= 3'd4) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [3:0] encode(input logic [2:0] s);
        logic [3:0] a;
        a = 4'b0000;
        case (s)
            3'd1:    a = 4'b0001;
            3'd2:    a = 4'b0010;
            3'd3:    a = 4'b0100;
            3'd4:    a = 4'b1000;
            default: a = 4'b0000;
        endcase
        return a;
    endfunction

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            slot_d  = 3'd0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d       = S_SHOW;
                    slot_d        = 3'd0;
                    cnt_d         = '0;
                    frame_start_d = 1'b1;
                end
                S_SHOW: begin
                    if (!hold) begin
                        if (cnt_q == DWELL_LAST) begin
                            cnt_d  = '0;
                            slot_d = next_slot(slot_q);
`ifdef SCAN_BLANK_EN
                            state_d = S_BLANK;
`else
                            frame_start_d = (slot_d == 3'd0);
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_BLANK: begin
`ifdef SCAN_BLANK_EN
                    // slot already points at the upcoming digit
                    if (cnt_q == BLANK_LAST) begin
                        state_d       = S_SHOW;
                        cnt_d         = '0;
                        frame_start_d = (slot_q == 3'd0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = S_SHOW;
                    cnt_d   = '0;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    slot_d  = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        adress_d   = (state_d == S_IDLE) ? 4'b0000 : encode(slot_d);
        digit_en_d = (state_d == S_SHOW) ? (5'd1 << slot_d) : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            slot_q        <= 3'd0;
            cnt_q         <= '0;
            adress_q      <= 4'b0000;
            digit_en_q    <= 5'b00000;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            adress_q      <= adress_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign adress      = adress_q;
    assign digit_en    = digit_en_q;
    assign slot        = slot_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with DWELL=4, BLANK=2.
// Behavioural model feeds an expected-output queue checked each cycle.
module tb_disp_scan_ctrl;

    localparam int DW = 4;
    localparam int BK = 2;
`ifdef SCAN_BLANK_EN
    localparam bit HAS_BLANK = 1'b1;
    localparam int FRAME = 5 * (DW + BK);
`else
    localparam bit HAS_BLANK = 1'b0;
    localparam int FRAME = 5 * DW;
`endif

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       hold;
    logic [3:0] adress;
    logic [4:0] digit_en;
    logic [2:0] slot;
    logic       frame_start;

    disp_scan_ctrl #(
        .DWELL(DW),
        .BLANK(BK),
        .CW   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .hold       (hold),
        .adress     (adress),
        .digit_en   (digit_en),
        .slot       (slot),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];

    int m_state;
    int m_slot;
    int m_cnt;
    bit m_fs;

    int cyc = 0;
    int fs_last = -1;
    int fs_seen = 0;
    bit per_on = 1'b0;
    logic [4:0] run_val = 5'b0;
    int run_len = 0;
    int len1 = 0;
    int len3 = 0;

    task automatic chk(input string tag, input logic [12:0] obs,
                       input logic [12:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_slot  = 0;
        m_cnt   = 0;
        m_fs    = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n || !enable) begin
            model_reset();
        end else if (m_state == 0) begin
            m_state = 1;
            m_slot  = 0;
            m_cnt   = 0;
            m_fs    = 1'b1;
        end else if (m_state == 1) begin
            m_fs = 1'b0;
            if (!hold) begin
                if (m_cnt == DW - 1) begin
                    m_cnt  = 0;
                    m_slot = (m_slot + 1) % 5;
                    if (HAS_BLANK) m_state = 2;
                    else m_fs = (m_slot == 0);
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            m_fs = 1'b0;
            if (m_cnt == BK - 1) begin
                m_state = 1;
                m_cnt   = 0;
                m_fs    = (m_slot == 0);
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [3:0] a;
        logic [4:0] d;
        a = 4'b0000;
        d = 5'b00000;
        if (m_state != 0 && m_slot != 0) a = 4'b0001 << (m_slot - 1);
        if (m_state == 1) d = 5'b00001 << m_slot;
        return {a, d, 3'(m_slot), m_fs};
    endfunction

    task automatic track();
        if (digit_en == run_val) begin
            run_len++;
        end else begin
            if (run_val == 5'b01000) len3 = run_len;
            if (run_val == 5'b00010) len1 = run_len;
            run_val = digit_en;
            run_len = 1;
        end
        if (frame_start) begin
            if (per_on && fs_last >= 0)
                chk("frame_period", 13'(cyc - fs_last), 13'(FRAME));
            fs_last = cyc;
            fs_seen++;
        end
    endtask

    task automatic tick();
        logic [12:0] e;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
        #1;
        cyc++;
        e = exp_q.pop_front();
        chk("scoreboard", {adress, digit_en, slot, frame_start}, e);
        track();
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b0;
        hold   = 1'b0;
        model_reset();
        #2;
        chk("reset_state", {adress, digit_en, slot, frame_start}, 13'd0);
        #15;
        rst_n = 1'b1;

        repeat (3) tick();

        enable = 1'b1;
        tick();
        chk("start_pulse", {digit_en, frame_start}, {5'b00001, 1'b1});
        per_on = 1'b1;
        fs_seen = 0;
        repeat (2 * FRAME + 2) tick();
        per_on = 1'b0;
        chk("frames_seen", 13'(fs_seen >= 2), 13'd1);
        chk("dwell_len", 13'(len1), 13'(DW));

        n = 0;
        while (digit_en != 5'b01000 && n < 100) begin
            tick();
            n++;
        end
        chk("to_slot3", 13'(n < 100), 13'd1);
        hold = 1'b1;
        repeat (10) tick();
        hold = 1'b0;
        n = 0;
        while (digit_en == 5'b01000 && n < 50) begin
            tick();
            n++;
        end
        chk("hold_len", 13'(len3), 13'(DW + 10));

        if (HAS_BLANK) begin
            n = 0;
            while (!(digit_en == 5'b0 && adress != 4'b0) && n < 100) begin
                tick();
                n++;
            end
            chk("to_blank_hold", 13'(n < 100), 13'd1);
            hold = 1'b1;
            repeat (2) tick();
            hold = 1'b0;
        end

        n = 0;
        while (!((HAS_BLANK && digit_en == 5'b0 && adress != 4'b0) ||
                 (!HAS_BLANK && digit_en != 5'b0)) && n < 100) begin
            tick();
            n++;
        end
        chk("to_disable", 13'(n < 100), 13'd1);
        enable = 1'b0;
        tick();
        chk("disable_idle", {adress, digit_en, slot, frame_start}, 13'd0);
        tick();
        enable = 1'b1;
        tick();
        chk("restart", {adress, digit_en, slot, frame_start},
            {4'b0000, 5'b00001, 3'd0, 1'b1});

        n = 0;
        while (digit_en != 5'b00100 && n < 100) begin
            tick();
            n++;
        end
        chk("to_slot2", 13'(n < 100), 13'd1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {adress, digit_en, slot, frame_start}, 13'd0);
        enable = 1'b0;
        model_reset();
        tick();
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_rst", {adress, digit_en, slot, frame_start}, 13'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Sequencer for the watch display datapath: drives the one-hot select bus of the 5-input, 8-bit data demux and the matching digit enables, so one display slot is shown at a time. It sits between the system clock domain and the display pins, and time-multiplexes slots 0..4 with a programmable dwell per slot. An optional blanking gap between slots lets the mux output settle and suppresses ghosting.

## Interface
- DWELL, 1000, clock cycles each slot is displayed (legal range 1..2^CW-1)
- BLANK, 16, clock cycles of blanking between slots (legal range 1..2^CW-1, used only with SCAN_BLANK_EN)
- CW, 16, width of the internal dwell/blank counter
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run scanning when 1; when 0, the block returns to idle
- hold  in  1  freeze the current slot; the dwell counter pauses (effective in SHOW only)
- adress  out  4  one-hot select to the demux: slot0=4'b0000, slot1=4'b0001, slot2=4'b0010, slot3=4'b0100, slot4=4'b1000
- digit_en  out  5  active-high digit enable, bit n = slot n, all zero when not showing
- slot  out  3  current slot index 0..4
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of slot 0

## Operation
- States: IDLE, SHOW, BLANK. Reset state is IDLE with slot=0, adress=4'b0000, digit_en=5'b00000, frame_start=0, counter=0.
- Priority, highest first: rst_n, then enable=0, then hold, then counting.
- IDLE: outputs are zero. When enable=1, the next state is SHOW with slot 0 and counter 0, and frame_start=1 for that cycle.
- SHOW: digit_en=1<<slot and adress=encode(slot). The counter increments each cycle unless hold=1.
  - On counter==DWELL-1 with hold=0 and SCAN_BLANK_EN defined: go to BLANK, counter 0, slot=next.
  - On counter==DWELL-1 with hold=0 and SCAN_BLANK_EN undefined: stay in SHOW, slot=next, counter 0.
- BLANK: digit_en=0. adress and slot already show the next slot, so the mux settles during the gap. hold is ignored. On counter==BLANK-1, go to SHOW with counter 0.
- next(slot): slot+1, wrapping 4->0. Entering SHOW with slot 0 from any state pulses frame_start.
- enable=0 in SHOW or BLANK: the next cycle is IDLE with all outputs zero and slot=0. There is no completion of the current dwell.
- hold=1 at counter==DWELL-1 keeps the block in SHOW. The transition happens on the first cycle with hold=0.
- The counter never exceeds max(DWELL,BLANK)-1. The slot value is never outside 0..4.

## Timing
- All outputs are registered and change only on the rising edge of clk, except on reset.
- rst_n low forces the reset values immediately (asynchronously). Release is synchronous to the next clk edge. Reset mid-frame discards all state.
- enable sampled high at edge N gives first SHOW outputs after edge N, i.e. one cycle of latency.
- adress and digit_en change on the same edge, with no skew cycle.
- Frame period is 5*(DWELL+BLANK) cycles with blanking and 5*DWELL without, with hold=0.

## Configuration
- SCAN_BLANK_EN:
  - Defined: the BLANK state exists and each slot is followed by BLANK cycles with digit_en=0.
  - Undefined: the BLANK state and the BLANK parameter are unused, and slots switch back-to-back.

## Test plan
All scenarios use DWELL=4 and BLANK=2.
- Async reset: pulse rst_n low mid-SHOW of slot 2 between edges -> adress=0000, digit_en=00000, slot=0, frame_start=0 immediately; the block stays in IDLE after release while enable=0.
- Start (SCAN_BLANK_EN defined): enable rises and is sampled at edge N -> from N+1, digit_en=00001 for 4 cycles with frame_start=1 only in the first. Then 2 cycles of digit_en=00000 with adress=0001, then digit_en=00010.
- Full frame (SCAN_BLANK_EN defined): frame_start pulses every 30 cycles and slot runs 0,1,2,3,4,0. adress runs 0000,0001,0010,0100,1000.
- Hold: hold=1 for 10 cycles during slot 3 SHOW -> digit_en=01000 lasts 14 cycles. A hold asserted during BLANK has no effect.
- Disable mid-BLANK: enable=0 sampled -> all outputs zero next cycle. Re-enable -> restarts at slot 0 with a frame_start pulse.
- SCAN_BLANK_EN undefined: digit_en=00001 for 4 cycles, then 00010 on the next cycle with no gap. The frame period is 20 cycles.
